// File: rtl/fake_dma_stream_engine.sv
// fake_dma_stream_engine
//   Register-driven stand-in for an AXI DMA. MM2S generates a programmable-length
//   AXI-Stream pattern (incrementing, Galois LFSR or constant). S2MM sinks a stream,
//   counts bytes and can compare the data against the same pattern generator, so a
//   loopback of MM2S into S2MM forms a closed-loop test. AXI-MM is left to the wrapper.
// Ports
//   m_axi_mm2s_aclk / axi_resetn        clock, async active-low reset
//   mm2s_dmacr/sa/length/length_we/ioc_clr, mm2s_dmasr, mm2s_introut   MM2S control/status
//   m_axis_mm2s_*                        generated stream
//   s2mm_dmacr/da/length/length_we/ioc_clr, s2mm_dmasr, s2mm_introut,
//   s2mm_bytes_rcvd                      S2MM control/status
//   s_axis_s2mm_*                        sink stream
//
// MM2S FSM
//   state      | meaning
//   MM_HALTED  | RS=0, no stream activity
//   MM_IDLE    | RS=1, waiting for a length write
//   MM_STREAM  | presenting beats, one per accepted handshake
// S2MM FSM
//   state      | meaning
//   S2_HALTED  | RS=0, tready low
//   S2_IDLE    | RS=1, waiting for a length write to arm
//   S2_RECV    | accepting beats until tlast
module fake_dma_stream_engine #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 26
) (
  input  logic                m_axi_mm2s_aclk,
  input  logic                axi_resetn,
  input  logic [31:0]         mm2s_dmacr,
  input  logic [31:0]         mm2s_sa,
  input  logic [31:0]         mm2s_length,
  input  logic                mm2s_length_we,
  input  logic                mm2s_ioc_clr,
  output logic [31:0]         mm2s_dmasr,
  output logic                mm2s_introut,
  output logic [DATA_W-1:0]   m_axis_mm2s_tdata,
  output logic [DATA_W/8-1:0] m_axis_mm2s_tkeep,
  output logic                m_axis_mm2s_tlast,
  output logic                m_axis_mm2s_tvalid,
  input  logic                m_axis_mm2s_tready,
  input  logic [31:0]         s2mm_dmacr,
  input  logic [31:0]         s2mm_da,
  input  logic [31:0]         s2mm_length,
  input  logic                s2mm_length_we,
  input  logic                s2mm_ioc_clr,
  output logic [31:0]         s2mm_dmasr,
  output logic                s2mm_introut,
  output logic [LEN_W-1:0]    s2mm_bytes_rcvd,
  input  logic [DATA_W-1:0]   s_axis_s2mm_tdata,
  input  logic [DATA_W/8-1:0] s_axis_s2mm_tkeep,
  input  logic                s_axis_s2mm_tlast,
  input  logic                s_axis_s2mm_tvalid,
  output logic                s_axis_s2mm_tready
);
  localparam int LANES = DATA_W / 32;
  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = $clog2(BYTES);

  typedef enum logic [1:0] {MM_HALTED, MM_IDLE, MM_STREAM} mm2s_state_t;
  typedef enum logic [1:0] {S2_HALTED, S2_IDLE, S2_RECV} s2mm_state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // gen holds the word for lane 0 of the beat being produced.
  function automatic logic [DATA_W-1:0] pat_beat(input logic [31:0] gen, input logic [1:0] mode);
    logic [DATA_W-1:0] d;
    logic [31:0] x;
    d = '0;
    x = gen;
    for (int j = 0; j < LANES; j++) begin
      if (mode == 2'b00) d[j*32 +: 32] = gen + 32'(j);
      else if (mode == 2'b01) begin
        d[j*32 +: 32] = x;
        x = lfsr_step(x);
      end
      else d[j*32 +: 32] = gen;
    end
    return d;
  endfunction

  function automatic logic [31:0] pat_next(input logic [31:0] gen, input logic [1:0] mode);
    logic [31:0] x;
    x = gen;
    if (mode == 2'b00) x = gen + 32'(LANES);
    else if (mode == 2'b01)
      for (int j = 0; j < LANES; j++) x = lfsr_step(x);
    return x;
  endfunction

  function automatic logic [31:0] seed_fix(input logic [31:0] seed, input logic [1:0] mode);
    return (mode == 2'b01 && seed == 32'h0) ? 32'h1 : seed;
  endfunction

  // ---------------- MM2S ----------------
  mm2s_state_t           mm2s_state, mm2s_next;
  logic                  mm2s_load, mm2s_ioc_set, mm2s_ioc, mm2s_abort;
  logic [31:0]           mm2s_gen;
  logic [LEN_W-1:0]      mm2s_beats_left;
  logic [BYTES-1:0]      mm2s_last_keep, mm2s_last_keep_in;
  logic [LEN_W-1:0]      mm2s_len;
  logic [LEN_W:0]        mm2s_nbeats;
  logic [LEN_W-1:0]      mm2s_nbeats_m1;
  logic [BSH-1:0]        mm2s_rem;
  logic [1:0]            mm2s_mode;
  logic                  mm2s_rs, mm2s_fire;
  logic [31:0]           mm2s_seed0;

  assign mm2s_rs        = mm2s_dmacr[0];
  assign mm2s_mode      = mm2s_dmacr[5:4];
  assign mm2s_len       = mm2s_length[LEN_W-1:0];
  assign mm2s_fire      = m_axis_mm2s_tvalid & m_axis_mm2s_tready;
  assign mm2s_nbeats    = ({1'b0, mm2s_len} + (LEN_W+1)'(BYTES-1)) >> BSH;
  assign mm2s_nbeats_m1 = mm2s_nbeats[LEN_W-1:0] - LEN_W'(1);
  assign mm2s_rem       = mm2s_len[BSH-1:0];
  assign mm2s_seed0     = seed_fix(mm2s_sa, mm2s_mode);

  always_comb begin
    mm2s_last_keep_in = '0;
    for (int b = 0; b < BYTES; b++)
      mm2s_last_keep_in[b] = (mm2s_rem == '0) || (b < int'(mm2s_rem));
  end

  always_comb begin
    mm2s_next    = mm2s_state;
    mm2s_load    = 1'b0;
    mm2s_ioc_set = 1'b0;
    case (mm2s_state)
      MM_HALTED: if (mm2s_rs) mm2s_next = MM_IDLE;
      MM_IDLE: begin
        if (!mm2s_rs) mm2s_next = MM_HALTED;
        else if (mm2s_length_we && mm2s_len != '0) begin
          mm2s_next = MM_STREAM;
          mm2s_load = 1'b1;
        end
      end
      MM_STREAM: begin
        if (mm2s_fire && m_axis_mm2s_tlast) begin
          // An aborted stream ends in HALTED without reporting completion.
          if (mm2s_abort || !mm2s_rs) mm2s_next = MM_HALTED;
          else begin
            mm2s_next    = MM_IDLE;
            mm2s_ioc_set = 1'b1;
          end
        end
      end
      default: mm2s_next = MM_HALTED;
    endcase
  end

  always_ff @(posedge m_axi_mm2s_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      mm2s_state         <= MM_HALTED;
      m_axis_mm2s_tdata  <= '0;
      m_axis_mm2s_tkeep  <= '0;
      m_axis_mm2s_tlast  <= 1'b0;
      m_axis_mm2s_tvalid <= 1'b0;
      mm2s_gen           <= '0;
      mm2s_beats_left    <= '0;
      mm2s_last_keep     <= '0;
      mm2s_abort         <= 1'b0;
      mm2s_ioc           <= 1'b0;
    end else begin
      mm2s_state <= mm2s_next;
      mm2s_ioc   <= mm2s_ioc_set | (mm2s_ioc & ~mm2s_ioc_clr);
      if (mm2s_load) begin
        m_axis_mm2s_tdata  <= pat_beat(mm2s_seed0, mm2s_mode);
        mm2s_gen           <= pat_next(mm2s_seed0, mm2s_mode);
        m_axis_mm2s_tkeep  <= (mm2s_nbeats_m1 == '0) ? mm2s_last_keep_in : '1;
        m_axis_mm2s_tlast  <= (mm2s_nbeats_m1 == '0);
        m_axis_mm2s_tvalid <= 1'b1;
        mm2s_beats_left    <= mm2s_nbeats_m1;
        mm2s_last_keep     <= mm2s_last_keep_in;
        mm2s_abort         <= 1'b0;
      end else if (mm2s_state == MM_STREAM) begin
        if (mm2s_fire) begin
          if (m_axis_mm2s_tlast) begin
            m_axis_mm2s_tvalid <= 1'b0;
            m_axis_mm2s_tlast  <= 1'b0;
          end else begin
            m_axis_mm2s_tdata <= pat_beat(mm2s_gen, mm2s_mode);
            mm2s_gen          <= pat_next(mm2s_gen, mm2s_mode);
            mm2s_beats_left   <= mm2s_beats_left - LEN_W'(1);
            m_axis_mm2s_tkeep <= (mm2s_beats_left == LEN_W'(1)) ? mm2s_last_keep : '1;
            m_axis_mm2s_tlast <= (mm2s_beats_left == LEN_W'(1)) || !mm2s_rs;
          end
        end else if (!mm2s_rs) begin
          // Run/stop dropped: the beat already on the bus becomes the last one.
          m_axis_mm2s_tlast <= 1'b1;
        end
        if (!mm2s_rs) mm2s_abort <= 1'b1;
      end
    end
  end

  assign mm2s_dmasr   = {19'd0, mm2s_ioc, 10'd0, mm2s_state == MM_IDLE, mm2s_state == MM_HALTED};
  assign mm2s_introut = mm2s_ioc & mm2s_dmacr[12];

  // ---------------- S2MM ----------------
  s2mm_state_t      s2mm_state, s2mm_next;
  logic             s2mm_arm, s2mm_ioc_set, s2mm_ovf_set, s2mm_mis_set;
  logic             s2mm_ioc, s2mm_ovf, s2mm_mis;
  logic [31:0]      s2mm_gen;
  logic [LEN_W-1:0] s2mm_exp_len;
  logic [LEN_W:0]   s2mm_sum;
  logic [DATA_W-1:0] s2mm_mask;
  logic [1:0]       s2mm_mode;
  logic             s2mm_rs, s2mm_fire;

  assign s2mm_rs            = s2mm_dmacr[0];
  assign s2mm_mode          = s2mm_dmacr[5:4];
  assign s_axis_s2mm_tready = s2mm_rs & (s2mm_state == S2_RECV);
  assign s2mm_fire          = s_axis_s2mm_tvalid & s_axis_s2mm_tready;

  always_comb begin
    s2mm_sum  = {1'b0, s2mm_bytes_rcvd};
    s2mm_mask = '0;
    for (int b = 0; b < BYTES; b++) begin
      s2mm_sum = s2mm_sum + {{LEN_W{1'b0}}, s_axis_s2mm_tkeep[b]};
      s2mm_mask[b*8 +: 8] = {8{s_axis_s2mm_tkeep[b]}};
    end
  end

  always_comb begin
    s2mm_next    = s2mm_state;
    s2mm_arm     = 1'b0;
    s2mm_ioc_set = 1'b0;
    case (s2mm_state)
      S2_HALTED: if (s2mm_rs) s2mm_next = S2_IDLE;
      S2_IDLE: begin
        if (!s2mm_rs) s2mm_next = S2_HALTED;
        else if (s2mm_length_we) begin
          s2mm_next = S2_RECV;
          s2mm_arm  = 1'b1;
        end
      end
      S2_RECV: begin
        if (!s2mm_rs) s2mm_next = S2_HALTED;
        else if (s2mm_fire && s_axis_s2mm_tlast) begin
          s2mm_next    = S2_IDLE;
          s2mm_ioc_set = 1'b1;
        end
      end
      default: s2mm_next = S2_HALTED;
    endcase
    s2mm_ovf_set = s2mm_fire && (s2mm_sum > {1'b0, s2mm_exp_len});
    s2mm_mis_set = s2mm_fire && (s2mm_mode != 2'b11) &&
                   (|((s_axis_s2mm_tdata ^ pat_beat(s2mm_gen, s2mm_mode)) & s2mm_mask));
  end

  always_ff @(posedge m_axi_mm2s_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      s2mm_state      <= S2_HALTED;
      s2mm_bytes_rcvd <= '0;
      s2mm_exp_len    <= '0;
      s2mm_gen        <= '0;
      s2mm_ioc        <= 1'b0;
      s2mm_ovf        <= 1'b0;
      s2mm_mis        <= 1'b0;
    end else begin
      s2mm_state <= s2mm_next;
      s2mm_ioc   <= s2mm_ioc_set | (s2mm_ioc & ~s2mm_ioc_clr);
      s2mm_ovf   <= s2mm_ovf_set | (s2mm_ovf & ~s2mm_ioc_clr);
      s2mm_mis   <= s2mm_mis_set | (s2mm_mis & ~s2mm_ioc_clr);
      if (s2mm_arm) begin
        s2mm_bytes_rcvd <= '0;
        s2mm_exp_len    <= s2mm_length[LEN_W-1:0];
        s2mm_gen        <= seed_fix(s2mm_da, s2mm_mode);
      end else if (s2mm_fire) begin
        s2mm_bytes_rcvd <= s2mm_sum[LEN_W] ? '1 : s2mm_sum[LEN_W-1:0];
        s2mm_gen        <= pat_next(s2mm_gen, s2mm_mode);
      end
    end
  end

  assign s2mm_dmasr   = {19'd0, s2mm_ioc, 5'd0, s2mm_mis, 1'b0, s2mm_ovf, 2'd0,
                         s2mm_state == S2_IDLE, s2mm_state == S2_HALTED};
  assign s2mm_introut = s2mm_ioc & s2mm_dmacr[12];

  logic unused_bits;
  assign unused_bits = ^{mm2s_dmacr[31:13], mm2s_dmacr[11:6], mm2s_dmacr[3:1],
                         s2mm_dmacr[31:13], s2mm_dmacr[11:6], s2mm_dmacr[3:1],
                         mm2s_length[31:LEN_W], s2mm_length[31:LEN_W], mm2s_nbeats[LEN_W]};
endmodule

// File: tb/tb_fake_dma_stream_engine.sv
module tb_fake_dma_stream_engine;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 26;
  localparam int BYTES  = DATA_W / 8;
  localparam int LANES  = DATA_W / 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] mm2s_dmacr, mm2s_sa, mm2s_length, s2mm_dmacr, s2mm_da, s2mm_length;
  logic mm2s_length_we, mm2s_ioc_clr, s2mm_length_we, s2mm_ioc_clr;
  logic [31:0] mm2s_dmasr, s2mm_dmasr;
  logic mm2s_introut, s2mm_introut;
  logic [LEN_W-1:0] s2mm_bytes_rcvd;
  logic [DATA_W-1:0] m_tdata, s_tdata, tb_s_tdata;
  logic [BYTES-1:0]  m_tkeep, s_tkeep, tb_s_tkeep;
  logic m_tlast, m_tvalid, m_tready, s_tlast, s_tvalid, s_tready;
  logic tb_m_tready, tb_s_tlast, tb_s_tvalid, loopback, rand_ready;

  assign m_tready = loopback ? s_tready : tb_m_tready;
  assign s_tdata  = loopback ? m_tdata  : tb_s_tdata;
  assign s_tkeep  = loopback ? m_tkeep  : tb_s_tkeep;
  assign s_tlast  = loopback ? m_tlast  : tb_s_tlast;
  assign s_tvalid = loopback ? m_tvalid : tb_s_tvalid;

  fake_dma_stream_engine #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .m_axi_mm2s_aclk(clk), .axi_resetn(rst_n),
    .mm2s_dmacr(mm2s_dmacr), .mm2s_sa(mm2s_sa), .mm2s_length(mm2s_length),
    .mm2s_length_we(mm2s_length_we), .mm2s_ioc_clr(mm2s_ioc_clr),
    .mm2s_dmasr(mm2s_dmasr), .mm2s_introut(mm2s_introut),
    .m_axis_mm2s_tdata(m_tdata), .m_axis_mm2s_tkeep(m_tkeep), .m_axis_mm2s_tlast(m_tlast),
    .m_axis_mm2s_tvalid(m_tvalid), .m_axis_mm2s_tready(m_tready),
    .s2mm_dmacr(s2mm_dmacr), .s2mm_da(s2mm_da), .s2mm_length(s2mm_length),
    .s2mm_length_we(s2mm_length_we), .s2mm_ioc_clr(s2mm_ioc_clr),
    .s2mm_dmasr(s2mm_dmasr), .s2mm_introut(s2mm_introut), .s2mm_bytes_rcvd(s2mm_bytes_rcvd),
    .s_axis_s2mm_tdata(s_tdata), .s_axis_s2mm_tkeep(s_tkeep), .s_axis_s2mm_tlast(s_tlast),
    .s_axis_s2mm_tvalid(s_tvalid), .s_axis_s2mm_tready(s_tready)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [BYTES-1:0]  k;
    logic              l;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] eff_seed(input logic [1:0] mode, input logic [31:0] seed);
    return (mode == 2'b01 && seed == 0) ? 32'h1 : seed;
  endfunction

  function automatic logic [31:0] cr(input logic [1:0] mode, input logic ie, input logic rs);
    return {19'd0, ie, 6'd0, mode, 3'd0, rs};
  endfunction

  // Reference: the pattern is a flat word stream w[0], w[1], ... packed LANES words per beat.
  task automatic push_mm2s(input logic [1:0] mode, input logic [31:0] seed, input int len, input int max_beats);
    int nb, n, rem;
    logic [31:0] x, w;
    beat_t b;
    nb  = (len + BYTES - 1) / BYTES;
    n   = (nb < max_beats) ? nb : max_beats;
    rem = len % BYTES;
    x   = eff_seed(mode, seed);
    for (int k = 0; k < n; k++) begin
      b = '0;
      for (int j = 0; j < LANES; j++) begin
        if (mode == 2'b00) w = seed + 32'(k * LANES + j);
        else if (mode == 2'b01) begin w = x; x = lfsr_step(x); end
        else w = seed;
        b.d[j*32 +: 32] = w;
      end
      b.k = '1;
      if (k == nb - 1 && rem != 0)
        for (int i = rem; i < BYTES; i++) b.k[i] = 1'b0;
      b.l = (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic monitor();
    logic stalled = 1'b0;
    logic [DATA_W-1:0] hd;
    logic [BYTES-1:0] hk;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin stalled = 1'b0; continue; end
      if (m_tvalid && stalled) begin
        check("stall_data_stable", 64'(m_tdata), 64'(hd));
        check("stall_keep_stable", 64'(m_tkeep), 64'(hk));
      end
      if (m_tvalid && m_tready) begin
        acc_cnt++;
        stalled = 1'b0;
        if (exp_q.size() == 0) check("unexpected_beat", 64'(m_tdata), 64'h0 - 1);
        else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(m_tdata), 64'(e.d));
          check("beat_keep", 64'(m_tkeep), 64'(e.k));
          check("beat_last", 64'(m_tlast), 64'(e.l));
        end
      end else if (m_tvalid) begin
        stalled = 1'b1; hd = m_tdata; hk = m_tkeep;
      end else stalled = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) tb_m_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mm2s_dmasr[1:0] == 2'b00 || s2mm_dmasr[1:0] == 2'b00) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("transfer_timeout", 64'(n), 64'(budget - 1));
  endtask

  task automatic start_mm2s(input int len);
    mm2s_length = 32'(len);
    mm2s_length_we = 1'b1;
    tick();
    mm2s_length_we = 1'b0;
  endtask

  task automatic run_loop(input logic [1:0] mode, input logic [31:0] ms, input logic [31:0] ss, input int len);
    loopback = 1'b1;
    mm2s_dmacr = cr(mode, 1'b1, 1'b1); mm2s_sa = ms;
    s2mm_dmacr = cr(mode, 1'b1, 1'b1); s2mm_da = ss;
    mm2s_ioc_clr = 1'b1; s2mm_ioc_clr = 1'b1; tick();
    mm2s_ioc_clr = 1'b0; s2mm_ioc_clr = 1'b0; tick();
    push_mm2s(mode, ms, len, 1 << 30);
    s2mm_length = 32'(len); s2mm_length_we = 1'b1;
    start_mm2s(len);
    s2mm_length_we = 1'b0;
    wait_done(3000);
  endtask

  task automatic send_s_beat(input logic [DATA_W-1:0] d, input logic [BYTES-1:0] k, input logic l);
    int n = 0;
    tb_s_tdata = d; tb_s_tkeep = k; tb_s_tlast = l; tb_s_tvalid = 1'b1;
    while (!s_tready && n < 50) begin tick(); n++; end
    if (n >= 50) check("s2mm_ready_timeout", 64'(n), 64'd0);
    tick();
    tb_s_tvalid = 1'b0;
  endtask

  initial begin
    int n, len;
    logic [1:0] mode;
    logic [31:0] ms, ss;
    rst_n = 1'b0; loopback = 1'b0; rand_ready = 1'b0; tb_m_tready = 1'b1;
    mm2s_dmacr = '0; mm2s_sa = '0; mm2s_length = '0; mm2s_length_we = 1'b0; mm2s_ioc_clr = 1'b0;
    s2mm_dmacr = '0; s2mm_da = '0; s2mm_length = '0; s2mm_length_we = 1'b0; s2mm_ioc_clr = 1'b0;
    tb_s_tdata = '0; tb_s_tkeep = '0; tb_s_tlast = 1'b0; tb_s_tvalid = 1'b0;
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
      end
    join_none
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_mm2s_dmasr", 64'(mm2s_dmasr), 64'h1);
    check("rst_s2mm_dmasr", 64'(s2mm_dmasr), 64'h1);
    check("rst_tvalid", 64'(m_tvalid), 64'h0);
    check("rst_tdata", 64'(m_tdata), 64'h0);
    check("rst_bytes", 64'(s2mm_bytes_rcvd), 64'h0);
    check("rst_intr", 64'({mm2s_introut, s2mm_introut}), 64'h0);

    // Incrementing pattern, full throughput, interrupt enabled
    mm2s_dmacr = cr(2'b00, 1'b1, 1'b1); mm2s_sa = 32'h100;
    s2mm_dmacr = cr(2'b11, 1'b0, 1'b1);
    tick(); tick();
    check("idle_mm2s_dmasr", 64'(mm2s_dmasr), 64'h2);
    push_mm2s(2'b00, 32'h100, 16, 1 << 30);
    start_mm2s(16);
    wait_done(100);
    check("t1_dmasr_ioc", 64'(mm2s_dmasr), 64'h1002);
    check("t1_introut_en", 64'(mm2s_introut), 64'h1);
    mm2s_dmacr = cr(2'b00, 1'b0, 1'b1);
    #1 check("t1_introut_dis", 64'(mm2s_introut), 64'h0);
    mm2s_ioc_clr = 1'b1; tick(); mm2s_ioc_clr = 1'b0;
    check("t1_ioc_cleared", 64'(mm2s_dmasr), 64'h2);

    // Zero length is ignored
    start_mm2s(0);
    tick(); tick();
    check("len0_no_ioc", 64'(mm2s_dmasr), 64'h2);
    check("len0_no_valid", 64'(m_tvalid), 64'h0);

    // Partial last beat with random backpressure
    rand_ready = 1'b1;
    push_mm2s(2'b00, 32'h100, 13, 1 << 30);
    start_mm2s(13);
    wait_done(200);
    // Randomized standalone transfers
    for (int t = 0; t < 8; t++) begin
      mode = 2'($urandom_range(0, 3));
      ms = $urandom;
      len = $urandom_range(1, 100);
      mm2s_dmacr = cr(mode, 1'b0, 1'b1); mm2s_sa = ms;
      push_mm2s(mode, ms, len, 1 << 30);
      start_mm2s(len);
      wait_done(1000);
    end
    rand_ready = 1'b0; tb_m_tready = 1'b1;

    // Loopback LFSR seed 0 on both sides
    run_loop(2'b01, 32'h0, 32'h0, 1024);
    check("t3_bytes", 64'(s2mm_bytes_rcvd), 64'd1024);
    check("t3_s2mm_dmasr", 64'(s2mm_dmasr), 64'h1002);
    check("t3_mm2s_ioc", 64'(mm2s_dmasr[12]), 64'h1);
    check("t3_s2mm_introut", 64'(s2mm_introut), 64'h1);

    // Randomized loopback, matching or differing seeds
    for (int t = 0; t < 5; t++) begin
      mode = 2'($urandom_range(0, 2));
      ms = $urandom;
      ss = ($urandom_range(0, 1) == 1) ? ms : $urandom;
      len = $urandom_range(8, 300);
      run_loop(mode, ms, ss, len);
      check("rl_bytes", 64'(s2mm_bytes_rcvd), 64'(len));
      check("rl_mismatch", 64'(s2mm_dmasr[6]), 64'(eff_seed(mode, ms) != eff_seed(mode, ss)));
      check("rl_ovf_ioc", 64'({s2mm_dmasr[4], s2mm_dmasr[12], mm2s_dmasr[12]}), 64'b011);
    end

    // Seed off by one, clear strobe coincident with the IOC set
    loopback = 1'b1;
    mm2s_dmacr = cr(2'b00, 1'b0, 1'b1); mm2s_sa = 32'h55;
    s2mm_dmacr = cr(2'b00, 1'b0, 1'b1); s2mm_da = 32'h56;
    mm2s_ioc_clr = 1'b1; s2mm_ioc_clr = 1'b1; tick();
    mm2s_ioc_clr = 1'b0; s2mm_ioc_clr = 1'b0;
    check("t4_ioc_pre", 64'(mm2s_dmasr[12]), 64'h0);
    push_mm2s(2'b00, 32'h55, 40, 1 << 30);
    s2mm_length = 32'd40; s2mm_length_we = 1'b1;
    start_mm2s(40);
    s2mm_length_we = 1'b0;
    n = 0;
    while (!(m_tvalid && m_tready && m_tlast) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("t4_last_timeout", 64'(n), 64'd0);
    mm2s_ioc_clr = 1'b1;
    @(posedge clk); #1 mm2s_ioc_clr = 1'b0;
    tick();
    check("t4_set_wins", 64'(mm2s_dmasr[12]), 64'h1);
    check("t4_mismatch", 64'(s2mm_dmasr), 64'h1042);
    s2mm_ioc_clr = 1'b1; tick(); s2mm_ioc_clr = 1'b0;
    check("t4_s2mm_clr", 64'(s2mm_dmasr), 64'h2);

    // Overflow: armed for 8 bytes, 12 arrive
    loopback = 1'b0;
    s2mm_dmacr = cr(2'b11, 1'b0, 1'b1);
    s2mm_length = 32'd8; s2mm_length_we = 1'b1; tick(); s2mm_length_we = 1'b0;
    send_s_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
    send_s_beat(64'h5555_6666_7777_8888, 8'h0F, 1'b1);
    check("t5_bytes", 64'(s2mm_bytes_rcvd), 64'd12);
    check("t5_dmasr", 64'(s2mm_dmasr), 64'h1012);

    // RS dropped while beat 3 of 10 is on the bus
    mm2s_dmacr = cr(2'b00, 1'b0, 1'b1); mm2s_sa = 32'h2000;
    mm2s_ioc_clr = 1'b1; tick(); mm2s_ioc_clr = 1'b0;
    tb_m_tready = 1'b1;
    acc_cnt = 0;
    push_mm2s(2'b00, 32'h2000, 80, 3);
    start_mm2s(80);
    n = 0;
    while (acc_cnt < 2 && n < 100) begin tick(); n++; end
    tb_m_tready = 1'b0;
    mm2s_dmacr = cr(2'b00, 1'b0, 1'b0);
    tick();
    tb_m_tready = 1'b1;
    tick(); tick();
    check("t6_beats", 64'(acc_cnt), 64'd3);
    check("t6_dmasr", 64'(mm2s_dmasr), 64'h1);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    // Async reset in the middle of a receive
    s2mm_dmacr = cr(2'b11, 1'b0, 1'b1);
    s2mm_length = 32'd64; s2mm_length_we = 1'b1; tick(); s2mm_length_we = 1'b0;
    check("t6_recv_ready", 64'(s_tready), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 64'(s_tready), 64'h0);
    check("t6_rst_s2mm_dmasr", 64'(s2mm_dmasr), 64'h1);
    check("t6_rst_mm2s_dmasr", 64'(mm2s_dmasr), 64'h1);
    tick();
    rst_n = 1'b1;
    tick();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
